// File: rtl/bit_entry_encoder.sv
// bit_entry_encoder: debounces two raw buttons into held one-hot bit requests (in1/in0) for a slow detector.
// Latency: press-to-request DEBOUNCE_CYCLES+3 clk edges; a request drops on the edge after the tick that consumes it.
// Backpressure: one request is held until tick; a press arriving while one is held is dropped and sets sticky overrun.
// Optional history shift register and saturating count are built only when BIT_ENTRY_HISTORY_EN is defined.

module bit_entry_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, CHK_DN, HELD, CHK_UP} db_state_e;

    logic             s1_q, s2_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // Two-flop synchronizer for the raw asynchronous button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn;
            s2_q <= s1_q;
        end
    end

    // Press/release qualification; the counter saturates at CNT_MAX so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = CHK_DN;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_DN: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s2_q) begin
                    state_d = CHK_UP;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_UP: begin
                if (s2_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Debounce state, counter and registered press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

module bit_entry_encoder #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HIST_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn1,
    input  logic                         btn0,
    input  logic                         tick,
    output logic                         in1,
    output logic                         in0,
    output logic                         pending,
    output logic                         overrun,
    output logic [HIST_W-1:0]            history,
    output logic [$clog2(HIST_W+1)-1:0]  hist_count
);
    localparam int HC_W = $clog2(HIST_W + 1);

    // One bit per request so in1/in0 come straight off flops.
    typedef enum logic [1:0] {EMPTY = 2'b00, PEND0 = 2'b01, PEND1 = 2'b10} req_state_e;

    logic       press1, press0;
    req_state_e req_q, req_d;
    logic       ovr_q, ovr_d;

    bit_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk(clk), .rst(rst), .btn(btn1), .press(press1)
    );
    bit_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db0 (
        .clk(clk), .rst(rst), .btn(btn0), .press(press0)
    );

    // Request hand-off: tick consumes the held bit, a same-cycle single press replaces it.
    always_comb begin
        req_d = req_q;
        ovr_d = ovr_q;
        if (press1 && press0) begin
            ovr_d = 1'b1;
            if (tick) begin
                req_d = EMPTY;
            end
        end else if (press1 || press0) begin
            if (req_q == EMPTY || tick) begin
                req_d = press1 ? PEND1 : PEND0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (tick) begin
            req_d = EMPTY;
        end
    end

    // Request state and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= EMPTY;
            ovr_q <= 1'b0;
        end else begin
            req_q <= req_d;
            ovr_q <= ovr_d;
        end
    end

    assign in1     = req_q[1];
    assign in0     = req_q[0];
    assign pending = req_q[1] | req_q[0];
    assign overrun = ovr_q;

`ifdef BIT_ENTRY_HISTORY_EN
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [HC_W-1:0]   hcnt_q, hcnt_d;

    // Shift in each accepted bit; the count saturates at HIST_W.
    always_comb begin
        hist_d = hist_q;
        hcnt_d = hcnt_q;
        if ((press1 ^ press0) && (req_q == EMPTY || tick)) begin
            hist_d = {hist_q[HIST_W-2:0], press1};
            if (hcnt_q != HC_W'(HIST_W)) begin
                hcnt_d = hcnt_q + HC_W'(1);
            end
        end
    end

    // History registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            hcnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            hcnt_q <= hcnt_d;
        end
    end

    assign history    = hist_q;
    assign hist_count = hcnt_q;
`else
    assign history    = '0;
    assign hist_count = '0;
`endif
endmodule

// File: tb/tb_bit_entry_encoder.sv
// Bench for bit_entry_encoder with DEBOUNCE_CYCLES=4, HIST_W=4.
// A cycle-level reference model (sample queue + run-length debounce + pending bit) is compared every negedge.
// Directed vector table and hand sequences cover latency, bounce, overrun, simultaneity, saturation and async reset.
module tb_bit_entry_encoder;
    localparam int D  = 4;
    localparam int HW = 4;
    localparam int CW = $clog2(HW + 1);

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic btn1 = 1'b0;
    logic btn0 = 1'b0;
    logic tick = 1'b0;
    logic in1, in0, pending, overrun;
    logic [HW-1:0] history;
    logic [CW-1:0] hist_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_entry_encoder #(.DEBOUNCE_CYCLES(D), .HIST_W(HW)) dut (
        .clk(clk), .rst(rst), .btn1(btn1), .btn0(btn0), .tick(tick),
        .in1(in1), .in0(in0), .pending(pending), .overrun(overrun),
        .history(history), .hist_count(hist_count)
    );

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    // History outputs only carry data when the history feature is built.
    function automatic int exp_h(input int v);
`ifdef BIT_ENTRY_HISTORY_EN
        return v;
`else
        return v * 0;
`endif
    endfunction

    // ---------------- reference model ----------------
    bit m_smp [2][2];   // [button][0]=latest sample, [1]=sample seen by debounce
    bit m_lvl [2];      // accepted level per button
    int m_run [2];      // consecutive samples disagreeing with accepted level
    bit m_prs [2];      // press seen by the request stage on the next edge
    int m_pend;         // -1 none, else pending bit value
    bit m_ovr;
    int m_hist, m_cnt;

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            m_smp[b][0] = 0; m_smp[b][1] = 0;
            m_lvl[b] = 0; m_run[b] = 0; m_prs[b] = 0;
        end
        m_pend = -1; m_ovr = 0; m_hist = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int nb;
        if (m_prs[1] && m_prs[0]) begin
            m_ovr = 1;
            if (tick) m_pend = -1;
        end else if (m_prs[1] || m_prs[0]) begin
            nb = m_prs[1] ? 1 : 0;
            if (m_pend < 0 || tick) begin
                m_pend = nb;
                m_hist = ((m_hist * 2) + nb) % (1 << HW);
                if (m_cnt < HW) m_cnt++;
            end else begin
                m_ovr = 1;
            end
        end else if (tick) begin
            m_pend = -1;
        end
        for (int b = 0; b < 2; b++) begin
            m_prs[b] = 0;
            if (m_smp[b][1] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == D + 1) begin
                    m_lvl[b] = m_smp[b][1];
                    m_run[b] = 0;
                    m_prs[b] = m_lvl[b];
                end
            end else begin
                m_run[b] = 0;
            end
            m_smp[b][1] = m_smp[b][0];
        end
        m_smp[1][0] = btn1;
        m_smp[0][0] = btn0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_in1", int'(in1), int'(m_pend == 1));
            chk("m_in0", int'(in0), int'(m_pend == 0));
            chk("m_pending", int'(pending), int'(m_pend >= 0));
            chk("m_overrun", int'(overrun), int'(m_ovr));
            chk("m_history", int'(history), exp_h(m_hist));
            chk("m_hist_count", int'(hist_count), exp_h(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn1 = 1'b0; btn0 = 1'b0; tick = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
    endtask

    // Edge 0 is the first posedge after the caller raised the button.
    task automatic measure_rise(input bit which, input int maxe, output int rise);
        rise = -1;
        for (int k = 0; k < maxe; k++) begin
            @(posedge clk); #1;
            if (rise < 0 && (which ? in1 : in0)) rise = k;
        end
    endtask

    typedef struct {
        bit bv; bit tf; bit e1; bit e0; bit eo; int eh; int ec;
    } vec_t;

    initial begin
        vec_t vt[6];
        int pat[7];
        int rp[6];
        int r, early, seen;
        bit l1, l0;

        vt[0] = '{1, 0, 1, 0, 0,  1, 1};
        vt[1] = '{1, 1, 1, 0, 0,  3, 2};
        vt[2] = '{0, 1, 0, 1, 0,  6, 3};
        vt[3] = '{1, 1, 1, 0, 0, 13, 4};
        vt[4] = '{1, 1, 1, 0, 0, 11, 4};
        vt[5] = '{0, 0, 1, 0, 1, 11, 4};
        pat = '{1, 1, 0, 1, 1, 1, 0};
        rp  = '{0, 1, 0, 0, 1, 0};

        // Reset state.
        @(negedge clk);
        chk("rst_in1", int'(in1), 0);
        chk("rst_in0", int'(in0), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_hist_count", int'(hist_count), 0);
        rst = 1'b0;

        // Single press latency and tick consumption.
        @(negedge clk); btn1 = 1'b1;
        measure_rise(1'b1, 20, r);
        chk("lat_in1", r, D + 3);
        chk("held_in1", int'(in1), 1);
        chk("single_history", int'(history), exp_h(1));
        chk("single_hist_count", int'(hist_count), exp_h(1));
        @(negedge clk); tick = 1'b1;
        chk("in1_during_tick", int'(in1), 1);
        @(posedge clk); #1; tick = 1'b0;
        chk("in1_after_tick", int'(in1), 0);
        btn1 = 1'b0;
        cyc(12);

        // Bounced press of btn0, then short release, bounced release, re-press.
        early = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); btn0 = pat[i][0];
            early += int'(in0);
        end
        @(negedge clk); btn0 = 1'b1;
        measure_rise(1'b0, 20, r);
        chk("bounce_early", early, 0);
        chk("bounce_lat", r, D + 3);
        pulse_tick();
        btn0 = 1'b0; cyc(3); btn0 = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin @(negedge clk); seen += int'(in0); end
        chk("short_release_no_req", seen, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); btn0 = rp[i][0];
            seen += int'(in0);
        end
        for (int i = 0; i < 12; i++) begin @(negedge clk); seen += int'(in0); end
        chk("bounced_release_no_req", seen, 0);
        btn0 = 1'b1;
        measure_rise(1'b0, 20, r);
        chk("repress_lat", r, D + 3);
        pulse_tick();
        btn0 = 1'b0;
        cyc(12);

        // Vector table: saturation of history and overrun on a dropped press.
        do_reset();
        foreach (vt[i]) begin
            if (vt[i].tf) pulse_tick();
            @(negedge clk);
            if (vt[i].bv) btn1 = 1'b1; else btn0 = 1'b1;
            cyc(12);
            chk($sformatf("vec%0d_in1", i), int'(in1), int'(vt[i].e1));
            chk($sformatf("vec%0d_in0", i), int'(in0), int'(vt[i].e0));
            chk($sformatf("vec%0d_overrun", i), int'(overrun), int'(vt[i].eo));
            chk($sformatf("vec%0d_history", i), int'(history), exp_h(vt[i].eh));
            chk($sformatf("vec%0d_hist_count", i), int'(hist_count), exp_h(vt[i].ec));
            btn1 = 1'b0; btn0 = 1'b0;
            cyc(12);
        end

        // Both press pulses in the same cycle.
        do_reset();
        @(negedge clk); btn1 = 1'b1; btn0 = 1'b1;
        cyc(12);
        chk("both_in1", int'(in1), 0);
        chk("both_in0", int'(in0), 0);
        chk("both_overrun", int'(overrun), 1);
        chk("both_hist_count", int'(hist_count), 0);
        btn1 = 1'b0; btn0 = 1'b0;
        cyc(12);

        // Tick coinciding with a new "0" press while "1" is pending.
        do_reset();
        @(negedge clk); btn1 = 1'b1; cyc(12); btn1 = 1'b0; cyc(12);
        btn0 = 1'b1;
        repeat (D + 3) @(posedge clk);
        @(negedge clk); tick = 1'b1;
        chk("swap_before_in1", int'(in1), 1);
        chk("swap_before_in0", int'(in0), 0);
        @(posedge clk); #1; tick = 1'b0;
        chk("swap_in1", int'(in1), 0);
        chk("swap_in0", int'(in0), 1);
        chk("swap_overrun", int'(overrun), 0);
        btn0 = 1'b0;
        cyc(12);

        // Asynchronous reset while pending with overrun set, then full re-debounce.
        do_reset();
        @(negedge clk); btn1 = 1'b1; cyc(12);
        btn0 = 1'b1; cyc(12);
        chk("pre_arst_overrun", int'(overrun), 1);
        @(posedge clk); #2; rst = 1'b1; #1;
        chk("arst_in1", int'(in1), 0);
        chk("arst_pending", int'(pending), 0);
        chk("arst_overrun", int'(overrun), 0);
        chk("arst_history", int'(history), 0);
        chk("arst_hist_count", int'(hist_count), 0);
        @(negedge clk); rst = 1'b0; btn0 = 1'b0;
        measure_rise(1'b1, 20, r);
        chk("post_arst_lat", r, D + 3);
        pulse_tick();
        btn1 = 1'b0; cyc(12);

        // Reset in the middle of a debounce.
        btn1 = 1'b1; cyc(3);
        rst = 1'b1; cyc(1); rst = 1'b0;
        measure_rise(1'b1, 20, r);
        chk("mid_debounce_rst_lat", r, D + 3);
        btn1 = 1'b0;

        // Randomized run against the model.
        do_reset();
        l1 = 1'b0; l0 = 1'b0;
        for (int s = 0; s < 240; s++) begin
            int dur;
            dur = int'($urandom_range(1, 14));
            if ($urandom_range(0, 2) == 0) l1 = ~l1;
            if ($urandom_range(0, 2) == 0) l0 = ~l0;
            if (s % 80 == 79) do_reset();
            for (int k = 0; k < dur; k++) begin
                @(negedge clk);
                btn1 = l1 ^ ($urandom_range(0, 9) == 0);
                btn0 = l0 ^ ($urandom_range(0, 9) == 0);
                tick = ($urandom_range(0, 5) == 0);
            end
        end
        @(negedge clk); tick = 1'b0; btn1 = 1'b0; btn0 = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
